// File: rtl/dht_frame_pkg.sv
// Shared state encodings, constants and byte-formatting helpers for the DHT frame
// sequencer and its UART byte handshake.
package dht_frame_pkg;

    localparam int CH_W = 32;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_SYNC  = 3'd2,
        ST_CHAN  = 3'd3,
        ST_GAP   = 3'd4,
        ST_TRAIL = 3'd5,
        ST_DONE  = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        HS_IDLE    = 2'd0,
        HS_LOAD    = 2'd1,
        HS_WAIT_HI = 2'd2,
        HS_WAIT_LO = 2'd3
    } hs_state_e;

    function automatic logic [7:0] index_byte(input logic [2:0] ch);
        return {5'b00000, ch};
    endfunction

    // Byte 'pos' of a snapshot word, counted from the most significant byte.
    function automatic logic [7:0] data_byte(input logic [CH_W-1:0] w, input logic [1:0] pos);
        logic [7:0] b;
        case (pos)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_byte_handshake.sv
// One-byte send handshake towards uart_tx: strobe when the transmitter is free,
// wait for busy to rise (with watchdog) and then fall, report byte_done/timeout.
module uart_byte_handshake
    import dht_frame_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    input  logic       tx_busy_i,
    output logic [7:0] tx_data_o,
    output logic       tx_send_o,
    output logic       byte_done_o,
    output logic       timeout_o
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    hs_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    pend_q, pend_d;
    logic [7:0]    data_q, data_d;
    logic          send_q, send_d;
    logic          busy_prev_q;
    logic          timer_exp_s;
    logic          fall_s;

    // Next-state, strobe generation and completion detection.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pend_d      = pend_q;
        data_d      = data_q;
        send_d      = 1'b0;
        byte_done_o = 1'b0;
        timeout_o   = 1'b0;
        timer_exp_s = (timer_q == TW'(ACK_TIMEOUT - 1));
        fall_s      = busy_prev_q && !tx_busy_i;

        case (state_q)
            HS_LOAD: begin
                if (!tx_busy_i && !send_q) begin
                    send_d  = 1'b1;
                    data_d  = pend_q;
                    timer_d = '0;
                    state_d = HS_WAIT_HI;
                end else begin
                    state_d = HS_LOAD;
                end
            end
            HS_WAIT_HI: begin
                if (tx_busy_i) begin
                    state_d = HS_WAIT_LO;
                end else if (timer_exp_s) begin
                    byte_done_o = 1'b1;
                    timeout_o   = 1'b1;
                    state_d     = HS_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HS_WAIT_LO: begin
                if (fall_s) begin
                    byte_done_o = 1'b1;
                    state_d     = HS_IDLE;
                end else begin
                    state_d = HS_WAIT_LO;
                end
            end
            default: state_d = HS_IDLE;
        endcase

        // The sequencer only requests a byte when idle or in the completion cycle,
        // so a request overrides whatever the branch above decided.
        if (start_i) begin
            pend_d = byte_i;
            if (!tx_busy_i && !send_q) begin
                send_d  = 1'b1;
                data_d  = byte_i;
                timer_d = '0;
                state_d = HS_WAIT_HI;
            end else begin
                state_d = HS_LOAD;
            end
        end else begin
            pend_d = pend_d;
        end
    end

    // Handshake state and registered UART outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HS_IDLE;
            timer_q     <= '0;
            pend_q      <= 8'h00;
            data_q      <= 8'h00;
            send_q      <= 1'b0;
            busy_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            data_q      <= data_d;
            send_q      <= send_d;
            busy_prev_q <= tx_busy_i;
        end
    end

    assign tx_data_o = data_q;
    assign tx_send_o = send_q;

endmodule

// File: rtl/dht_frame_sequencer.sv
// Snapshots NUM_CH DHT11 words and streams them as a framed byte sequence to uart_tx.
// Optional trailer: define FRAME_CHECKSUM_EN to append an XOR checksum of index and data bytes.
module dht_frame_sequencer
    import dht_frame_pkg::*;
#(
    parameter int         NUM_CH       = 2,
    parameter int         BYTES_PER_CH = 4,
    parameter int         GAP_CYCLES   = 2,
    parameter int         CONTINUOUS   = 0,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         ACK_TIMEOUT  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*CH_W-1:0]   ch_data,
    input  logic                     tx_busy,
    output logic [7:0]               tx_data,
    output logic                     tx_send,
    output logic                     frame_active,
    output logic [7:0]               frame_count,
    output logic                     ack_err,
    output logic [2:0]               debug_state
);

    seq_state_e      state_q, state_d;
    logic [CH_W-1:0] snap_q [NUM_CH];
    logic [2:0]      ch_q, ch_d;
    logic [2:0]      byte_q, byte_d;
    logic [15:0]     gap_q, gap_d;
    logic [7:0]      csum_q, csum_d;
    logic [7:0]      frame_count_q, frame_count_d;
    logic            frame_active_q, frame_active_d;
    logic            ack_err_q, ack_err_d;
    logic            arm_q, arm_d;

    logic            all_valid_s;
    logic            latch_s;
    logic            start_s;
    logic [7:0]      byte_s;
    logic [CH_W-1:0] word_s;
    logic            hs_done_s;
    logic            hs_timeout_s;

    assign all_valid_s = &ch_valid;

    uart_byte_handshake #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_hs (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_s),
        .byte_i      (byte_s),
        .tx_busy_i   (tx_busy),
        .tx_data_o   (tx_data),
        .tx_send_o   (tx_send),
        .byte_done_o (hs_done_s),
        .timeout_o   (hs_timeout_s)
    );

    // Frame sequencing: each state issues the next byte in the cycle its previous byte completes.
    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        byte_d         = byte_q;
        gap_d          = gap_q;
        csum_d         = csum_q;
        frame_count_d  = frame_count_q;
        frame_active_d = frame_active_q;
        arm_d          = arm_q;
        ack_err_d      = ack_err_q | hs_timeout_s;
        latch_s        = 1'b0;
        start_s        = 1'b0;
        byte_s         = 8'h00;
        word_s         = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == 3'(k)) begin
                word_s = snap_q[k];
            end else begin
                word_s = word_s;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // arm_q blocks a retransmit until some channel has dropped valid.
                if (all_valid_s && arm_q) begin
                    latch_s        = 1'b1;
                    arm_d          = 1'b0;
                    ch_d           = 3'd0;
                    byte_d         = 3'd0;
                    frame_active_d = 1'b1;
                    state_d        = ST_LATCH;
                end else if (!all_valid_s) begin
                    arm_d = 1'b1;
                end else begin
                    arm_d = arm_q;
                end
            end
            ST_LATCH: begin
                start_s = 1'b1;
                byte_s  = SYNC_BYTE;
                csum_d  = 8'h00;
                state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (hs_done_s) begin
                    start_s = 1'b1;
                    byte_s  = index_byte(ch_q);
                    csum_d  = csum_q ^ byte_s;
                    state_d = ST_CHAN;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_CHAN: begin
                if (!hs_done_s) begin
                    state_d = ST_CHAN;
                end else if (byte_q != 3'(BYTES_PER_CH)) begin
                    start_s = 1'b1;
                    byte_s  = data_byte(word_s, byte_q[1:0]);
                    csum_d  = csum_q ^ byte_s;
                    byte_d  = byte_q + 3'd1;
                end else if (ch_q != 3'(NUM_CH - 1)) begin
                    gap_d   = 16'd0;
                    state_d = ST_GAP;
                end else begin
`ifdef FRAME_CHECKSUM_EN
                    start_s = 1'b1;
                    byte_s  = csum_q;
                    state_d = ST_TRAIL;
`else
                    frame_count_d  = frame_count_q + 8'd1;
                    frame_active_d = 1'b0;
                    state_d        = ST_DONE;
`endif
                end
            end
            ST_GAP: begin
                // Index byte is requested in the last gap clock so it strobes right after.
                if (gap_q == 16'(GAP_CYCLES - 1)) begin
                    ch_d    = ch_q + 3'd1;
                    byte_d  = 3'd0;
                    start_s = 1'b1;
                    byte_s  = index_byte(ch_q + 3'd1);
                    csum_d  = csum_q ^ byte_s;
                    state_d = ST_CHAN;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_TRAIL: begin
                if (hs_done_s) begin
                    frame_count_d  = frame_count_q + 8'd1;
                    frame_active_d = 1'b0;
                    state_d        = ST_DONE;
                end else begin
                    state_d = ST_TRAIL;
                end
            end
`endif
            ST_DONE: begin
                if (CONTINUOUS != 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers and snapshot capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ch_q           <= 3'd0;
            byte_q         <= 3'd0;
            gap_q          <= 16'd0;
            csum_q         <= 8'h00;
            frame_count_q  <= 8'h00;
            frame_active_q <= 1'b0;
            ack_err_q      <= 1'b0;
            arm_q          <= 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            byte_q         <= byte_d;
            gap_q          <= gap_d;
            csum_q         <= csum_d;
            frame_count_q  <= frame_count_d;
            frame_active_q <= frame_active_d;
            ack_err_q      <= ack_err_d;
            arm_q          <= arm_d;
            if (latch_s) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    snap_q[k] <= ch_data[k*CH_W +: CH_W];
                end
            end
        end
    end

    assign frame_active = frame_active_q;
    assign frame_count  = frame_count_q;
    assign ack_err      = ack_err_q;
    assign debug_state  = state_q;

endmodule

// File: tb/tb_dht_frame_sequencer.sv
// Scoreboard bench: a one-shot and a continuous sequencer, each driven by a UART busy model.
module tb_dht_frame_sequencer;

    localparam int NUM_CH   = 2;
    localparam int BPC      = 4;
    localparam int GAP      = 2;
    localparam int ACK_TO   = 16;
    localparam int BUSY_LEN = 10;
`ifdef FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = 1 + NUM_CH * (1 + BPC) + 1;
`else
    localparam int FRAME_LEN = 1 + NUM_CH * (1 + BPC);
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cv0, cvc;
    logic [63:0] ch_data;
    logic        busy0 = 1'b0, busyc = 1'b0;
    logic [7:0]  txd0, txdc, fc0, fcc;
    logic        send0, sendc, fa0, fac, ae0, aec;
    logic [2:0]  ds0, dsc;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [8:0] exp0[$];
    logic [8:0] expc[$];
    int sends0 = 0, sendsc = 0;
    int send_cyc0[$];
    int fall_cyc0[$];
    logic never_busy0 = 1'b0;
    int bcnt0 = 0, bcntc = 0;
    logic prev_send0 = 1'b0, prev_sendc = 1'b0, prev_busy0 = 1'b0;

    dht_frame_sequencer #(.NUM_CH(NUM_CH), .BYTES_PER_CH(BPC), .GAP_CYCLES(GAP),
                          .CONTINUOUS(0), .ACK_TIMEOUT(ACK_TO)) dut (
        .clk(clk), .reset(reset), .ch_valid(cv0), .ch_data(ch_data), .tx_busy(busy0),
        .tx_data(txd0), .tx_send(send0), .frame_active(fa0), .frame_count(fc0),
        .ack_err(ae0), .debug_state(ds0));

    dht_frame_sequencer #(.NUM_CH(NUM_CH), .BYTES_PER_CH(BPC), .GAP_CYCLES(GAP),
                          .CONTINUOUS(1), .ACK_TIMEOUT(ACK_TO)) dut_c (
        .clk(clk), .reset(reset), .ch_valid(cvc), .ch_data(ch_data), .tx_busy(busyc),
        .tx_data(txdc), .tx_send(sendc), .frame_active(fac), .frame_count(fcc),
        .ack_err(aec), .debug_state(dsc));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // UART model for the one-shot instance: busy for BUSY_LEN clocks after each strobe
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy0 <= 1'b0;
            bcnt0 <= 0;
        end else if (bcnt0 > 1) begin
            bcnt0 <= bcnt0 - 1;
        end else if (bcnt0 == 1) begin
            bcnt0 <= 0;
            busy0 <= 1'b0;
        end else if (send0 && !never_busy0) begin
            busy0 <= 1'b1;
            bcnt0 <= BUSY_LEN;
        end
    end

    // UART model for the continuous instance
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busyc <= 1'b0;
            bcntc <= 0;
        end else if (bcntc > 1) begin
            bcntc <= bcntc - 1;
        end else if (bcntc == 1) begin
            bcntc <= 0;
            busyc <= 1'b0;
        end else if (sendc) begin
            busyc <= 1'b1;
            bcntc <= BUSY_LEN;
        end
    end

    // Scoreboard for the one-shot instance; 9'h1FF can never match a byte
    always @(negedge clk) begin
        logic [8:0] e;
        if (send0) begin
            e = (exp0.size() > 0) ? exp0.pop_front() : 9'h1FF;
            check_eq("dut0_byte", {24'd0, 1'b0, txd0}, {23'd0, e});
            check_eq("dut0_strobe_back_to_back", {31'd0, prev_send0}, 32'd0);
            sends0++;
            send_cyc0.push_back(cyc);
        end
        if (prev_busy0 && !busy0) fall_cyc0.push_back(cyc);
        prev_send0 = send0;
        prev_busy0 = busy0;
    end

    // Scoreboard for the continuous instance
    always @(negedge clk) begin
        logic [8:0] e;
        if (sendc) begin
            e = (expc.size() > 0) ? expc.pop_front() : 9'h1FF;
            check_eq("dutc_byte", {24'd0, 1'b0, txdc}, {23'd0, e});
            check_eq("dutc_strobe_back_to_back", {31'd0, prev_sendc}, 32'd0);
            sendsc++;
        end
        prev_sendc = sendc;
    end

    task automatic push_frame(input logic [31:0] d0, input logic [31:0] d1, input bit to_c);
        logic [7:0]  b[$];
        logic [7:0]  cs;
        logic [31:0] w;
        b.push_back(8'hA5);
        for (int c = 0; c < NUM_CH; c++) begin
            w = (c == 0) ? d0 : d1;
            b.push_back(8'(c));
            for (int j = 0; j < BPC; j++) b.push_back(w[31 - 8*j -: 8]);
        end
        cs = 8'h00;
        for (int i = 1; i < b.size(); i++) cs = cs ^ b[i];
`ifdef FRAME_CHECKSUM_EN
        b.push_back(cs);
`endif
        for (int i = 0; i < b.size(); i++) begin
            if (to_c) expc.push_back({1'b0, b[i]});
            else      exp0.push_back({1'b0, b[i]});
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done0(input int budget);
        int n = 0;
        while (ds0 != 3'd6 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("dut0_reaches_done", {29'd0, ds0}, 32'd6);
    endtask

    task automatic wait_count_c(input logic [7:0] target, input int budget);
        int n = 0;
        while (fcc != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("dutc_frame_count", {24'd0, fcc}, {24'd0, target});
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base, basec, n, lat, d;
        logic [31:0] r0, r1;
        reset   = 1'b1;
        cv0     = 2'b00;
        cvc     = 2'b00;
        ch_data = 64'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_data", {24'd0, txd0}, 32'd0);
        check_eq("rst_tx_send", {31'd0, send0}, 32'd0);
        check_eq("rst_frame_active", {31'd0, fa0}, 32'd0);
        check_eq("rst_frame_count", {24'd0, fc0}, 32'd0);
        check_eq("rst_ack_err", {31'd0, ae0}, 32'd0);
        check_eq("rst_state", {29'd0, ds0}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic frame; inputs change right after the snapshot and must be ignored.
        ch_data = {32'h55667788, 32'h11223344};
        push_frame(32'h11223344, 32'h55667788, 1'b0);
        send_cyc0.delete();
        fall_cyc0.delete();
        base = sends0;
        cv0 = 2'b11;
        n = 0;
        while (!fa0 && n < 10) begin @(negedge clk); n++; end
        ch_data = {32'hDEADBEEF, 32'h0BADF00D};
        cv0 = 2'b10;
        wait_done0(3000);
        check_eq("frame1_count", {24'd0, fc0}, 32'd1);
        check_eq("frame1_active_low", {31'd0, fa0}, 32'd0);
        check_eq("frame1_bytes_sent", sends0 - base, FRAME_LEN);
        check_eq("frame1_queue_empty", exp0.size(), 32'd0);
        d = (send_cyc0.size() > 6 && fall_cyc0.size() > 5) ? send_cyc0[6] - fall_cyc0[5] : -1;
        check_eq("gap_fall_to_index", d, GAP + 1);
        repeat (200) @(negedge clk);
        check_eq("oneshot_frozen_state", {29'd0, ds0}, 32'd6);
        check_eq("oneshot_no_more_bytes", sends0 - base, FRAME_LEN);
        check_eq("oneshot_count_held", {24'd0, fc0}, 32'd1);

        // Partial valid holds the sequencer idle; completing it starts a frame quickly.
        cv0 = 2'b00;
        apply_reset();
        ch_data = {32'h8899AABB, 32'hCAFE0102};
        cv0 = 2'b01;
        base = sends0;
        repeat (1000) @(negedge clk);
        check_eq("partial_valid_no_send", sends0 - base, 0);
        check_eq("partial_valid_idle", {29'd0, ds0}, 32'd0);
        check_eq("partial_valid_inactive", {31'd0, fa0}, 32'd0);
        push_frame(32'hCAFE0102, 32'h8899AABB, 1'b0);
        cv0 = 2'b11;
        lat = 0;
        while (!send0 && lat < 10) begin @(negedge clk); lat++; end
        check_eq("start_within_2_clocks", {31'd0, (lat >= 1 && lat <= 2)}, 32'd1);
        wait_done0(3000);
        check_eq("frame2_count", {24'd0, fc0}, 32'd1);
        check_eq("frame2_queue_empty", exp0.size(), 32'd0);

        // Reset in the middle of the third byte aborts; a fresh frame follows.
        cv0 = 2'b00;
        apply_reset();
        ch_data = {32'h13579BDF, 32'h2468ACE0};
        push_frame(32'h2468ACE0, 32'h13579BDF, 1'b0);
        base = sends0;
        cv0 = 2'b11;
        n = 0;
        while (sends0 - base < 3 && n < 500) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_tx_data", {24'd0, txd0}, 32'd0);
        check_eq("midrst_tx_send", {31'd0, send0}, 32'd0);
        check_eq("midrst_frame_active", {31'd0, fa0}, 32'd0);
        check_eq("midrst_state", {29'd0, ds0}, 32'd0);
        exp0.delete();
        ch_data = {32'hF0E1D2C3, 32'h0F1E2D3C};
        push_frame(32'h0F1E2D3C, 32'hF0E1D2C3, 1'b0);
        base = sends0;
        @(negedge clk);
        reset = 1'b0;
        wait_done0(3000);
        check_eq("after_rst_bytes_sent", sends0 - base, FRAME_LEN);
        check_eq("after_rst_queue_empty", exp0.size(), 32'd0);
        check_eq("after_rst_count", {24'd0, fc0}, 32'd1);

        // Transmitter never acknowledges: watchdog advances every byte.
        cv0 = 2'b00;
        never_busy0 = 1'b1;
        apply_reset();
        ch_data = {32'h00FF00FF, 32'hA5A55A5A};
        push_frame(32'hA5A55A5A, 32'h00FF00FF, 1'b0);
        base = sends0;
        send_cyc0.delete();
        cv0 = 2'b11;
        wait_done0(3000);
        check_eq("timeout_ack_err", {31'd0, ae0}, 32'd1);
        check_eq("timeout_frame_count", {24'd0, fc0}, 32'd1);
        check_eq("timeout_bytes_sent", sends0 - base, FRAME_LEN);
        check_eq("timeout_queue_empty", exp0.size(), 32'd0);
        d = (send_cyc0.size() > 1) ? send_cyc0[1] - send_cyc0[0] : -1;
        check_eq("timeout_byte_interval", {31'd0, (d >= ACK_TO && d <= ACK_TO + 1)}, 32'd1);
        repeat (50) @(negedge clk);
        check_eq("ack_err_sticky", {31'd0, ae0}, 32'd1);
        never_busy0 = 1'b0;
        cv0 = 2'b00;

        // Continuous mode: one frame per valid assertion, counter wraps after 256.
        apply_reset();
        ch_data = {32'h55667788, 32'h11223344};
        push_frame(32'h11223344, 32'h55667788, 1'b1);
        basec = sendsc;
        cvc = 2'b11;
        wait_count_c(8'd1, 3000);
        repeat (300) @(negedge clk);
        check_eq("cont_single_frame_bytes", sendsc - basec, FRAME_LEN);
        check_eq("cont_count_held", {24'd0, fcc}, 32'd1);
        check_eq("cont_idle_state", {29'd0, dsc}, 32'd0);
        check_eq("cont_inactive", {31'd0, fac}, 32'd0);
        for (int f = 2; f <= 256; f++) begin
            cvc = 2'b01;
            repeat (2) @(negedge clk);
            r0 = $urandom;
            r1 = $urandom;
            ch_data = {r1, r0};
            push_frame(r0, r1, 1'b1);
            cvc = 2'b11;
            wait_count_c(8'(f), 1000);
        end
        check_eq("cont_count_wrapped", {24'd0, fcc}, 32'd0);
        check_eq("cont_queue_empty", expc.size(), 32'd0);
        check_eq("cont_ack_err_clear", {31'd0, aec}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
